// File: rtl/switch_counter_pkg.sv
// Shared types and constants for the switch-driven two-digit BCD counter.
package switch_counter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } state_t;

   typedef logic [3:0] bcd_digit_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   function automatic bcd_digit_t bcd_tens(input int unsigned i_Value);
      return bcd_digit_t'((i_Value / 10) % 10);
   endfunction

   function automatic bcd_digit_t bcd_ones(input int unsigned i_Value);
      return bcd_digit_t'(i_Value % 10);
   endfunction

endpackage

// File: rtl/bcd_updown_counter.sv
// Two-digit BCD register (00-99) with clear > load > up > down priority and wrap-around.
module bcd_updown_counter
   import switch_counter_pkg::*;
(
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic       i_Clear,
   input  logic       i_Load,
   input  bcd_digit_t i_LoadTens,
   input  bcd_digit_t i_LoadOnes,
   input  logic       i_Up,
   input  logic       i_Down,
   output bcd_digit_t o_Tens,
   output bcd_digit_t o_Ones
);

   bcd_digit_t r_Tens;
   bcd_digit_t r_Ones;
   bcd_digit_t w_TensNext;
   bcd_digit_t w_OnesNext;

   always_comb begin
      w_TensNext = r_Tens;
      w_OnesNext = r_Ones;
      if (i_Clear) begin
         w_TensNext = 4'd0;
         w_OnesNext = 4'd0;
      end else if (i_Load) begin
         w_TensNext = i_LoadTens;
         w_OnesNext = i_LoadOnes;
      end else if (i_Up) begin
         if (r_Ones == 4'd9) begin
            w_OnesNext = 4'd0;
            w_TensNext = (r_Tens == 4'd9) ? 4'd0 : r_Tens + 4'd1;
         end else begin
            w_OnesNext = r_Ones + 4'd1;
         end
      end else if (i_Down) begin
         if (r_Ones == 4'd0) begin
            w_OnesNext = 4'd9;
            w_TensNext = (r_Tens == 4'd0) ? 4'd9 : r_Tens - 4'd1;
         end else begin
            w_OnesNext = r_Ones - 4'd1;
         end
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_Tens <= 4'd0;
         r_Ones <= 4'd0;
      end else begin
         r_Tens <= w_TensNext;
         r_Ones <= w_OnesNext;
      end
   end

   assign o_Tens = r_Tens;
   assign o_Ones = r_Ones;

endmodule

// File: rtl/switch_event_counter.sv
// Turns debounced switch levels into BCD counter actions, with hold-to-repeat on up/down.
module switch_event_counter
   import switch_counter_pkg::*;
#(
   parameter int unsigned REPEAT_DELAY  = 12_500_000,
   parameter int unsigned REPEAT_PERIOD = 2_500_000,
   parameter int unsigned PRESET        = 50
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic [3:0] i_Switches,
   output logic [3:0] o_Tens,
   output logic [3:0] o_Ones,
   output logic       o_Step,
   output logic       o_Repeating
);

   localparam int unsigned TIMER_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                      : REPEAT_PERIOD;
   localparam int unsigned TIMER_W   = $clog2(TIMER_MAX);
   localparam logic [TIMER_W-1:0] DELAY_RELOAD  = TIMER_W'(REPEAT_DELAY - 1);
   localparam logic [TIMER_W-1:0] PERIOD_RELOAD = TIMER_W'(REPEAT_PERIOD - 1);
   localparam bcd_digit_t PRESET_TENS = bcd_tens(PRESET);
   localparam bcd_digit_t PRESET_ONES = bcd_ones(PRESET);

   logic [3:0]         r_Switches;
   state_t             r_State;
   state_t             w_StateNext;
   logic [TIMER_W-1:0] r_Timer;
   logic [TIMER_W-1:0] w_TimerNext;
   logic               r_Dir;
   logic               w_DirNext;
   logic               r_Step;
   logic               r_Repeating;

   logic [3:0] w_Press;
   logic       w_Clear;
   logic       w_Load;
   logic       w_BothDir;
   logic       w_Held;
   logic       w_Other;
   logic       w_StepEn;
   logic       w_StepDir;
   logic       w_Up;
   logic       w_Down;

   always_comb begin
      w_Press     = i_Switches & ~r_Switches;
      w_Clear     = w_Press[2];
      w_Load      = w_Press[3];
      w_BothDir   = &i_Switches[1:0];
      w_Held      = (r_Dir == DIR_UP) ? i_Switches[0] : i_Switches[1];
      w_Other     = (r_Dir == DIR_UP) ? i_Switches[1] : i_Switches[0];
      w_StateNext = r_State;
      w_TimerNext = r_Timer;
      w_DirNext   = r_Dir;
      w_StepEn    = 1'b0;
      w_StepDir   = r_Dir;
      case (r_State)
         IDLE: begin
            // Clear/preset outrank a coincident direction press; FSM stays idle then.
            if (!w_Clear && !w_Load && !w_BothDir && (w_Press[0] ^ w_Press[1])) begin
               w_StepEn    = 1'b1;
               w_DirNext   = w_Press[1] ? DIR_DOWN : DIR_UP;
               w_StepDir   = w_DirNext;
               w_TimerNext = DELAY_RELOAD;
               w_StateNext = DELAY;
            end
         end
         DELAY, REPEAT: begin
            if (!w_Held || w_Other || w_Clear || w_Load) begin
               w_StateNext = IDLE;
               w_TimerNext = '0;
            end else if (r_Timer == '0) begin
               w_StepEn    = 1'b1;
               w_TimerNext = PERIOD_RELOAD;
               w_StateNext = REPEAT;
            end else begin
               w_TimerNext = r_Timer - 1'b1;
            end
         end
         default: begin
            w_StateNext = IDLE;
            w_TimerNext = '0;
         end
      endcase
      w_Up   = w_StepEn & (w_StepDir == DIR_UP);
      w_Down = w_StepEn & (w_StepDir == DIR_DOWN);
   end

   always_ff @(posedge i_Clk) begin
      // Capturing the live switches during reset hides any switch held through it.
      r_Switches <= i_Switches;
      if (i_Reset) begin
         r_State     <= IDLE;
         r_Timer     <= '0;
         r_Dir       <= DIR_UP;
         r_Step      <= 1'b0;
         r_Repeating <= 1'b0;
      end else begin
         r_State     <= w_StateNext;
         r_Timer     <= w_TimerNext;
         r_Dir       <= w_DirNext;
         r_Step      <= w_StepEn | w_Clear | w_Load;
         r_Repeating <= (w_StateNext == REPEAT);
      end
   end

   bcd_updown_counter u_bcd (
      .i_Clk      (i_Clk),
      .i_Reset    (i_Reset),
      .i_Clear    (w_Clear),
      .i_Load     (w_Load),
      .i_LoadTens (PRESET_TENS),
      .i_LoadOnes (PRESET_ONES),
      .i_Up       (w_Up),
      .i_Down     (w_Down),
      .o_Tens     (o_Tens),
      .o_Ones     (o_Ones)
   );

   assign o_Step      = r_Step;
   assign o_Repeating = r_Repeating;

endmodule

// File: tb/tb_switch_event_counter.sv
// Self-checking bench for switch_event_counter with short repeat timings.
module tb_switch_event_counter;

   logic       i_Clk;
   logic       i_Reset;
   logic [3:0] i_Switches;
   logic [3:0] o_Tens;
   logic [3:0] o_Ones;
   logic       o_Step;
   logic       o_Repeating;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected {tens, ones, step, repeating} after each driven edge.
   logic [9:0] exp_q[$];

   switch_event_counter #(
      .REPEAT_DELAY  (8),
      .REPEAT_PERIOD (4),
      .PRESET        (50)
   ) dut (
      .i_Clk       (i_Clk),
      .i_Reset     (i_Reset),
      .i_Switches  (i_Switches),
      .o_Tens      (o_Tens),
      .o_Ones      (o_Ones),
      .o_Step      (o_Step),
      .o_Repeating (o_Repeating)
   );

   initial i_Clk = 1'b0;
   always #5 i_Clk = ~i_Clk;

   // Row = {switches, reset, expected BCD value, expected step, expected repeating}.
   function automatic logic [14:0] row(input logic [3:0] sw, input logic rst,
                                       input logic [7:0] val, input logic stp,
                                       input logic rep);
      return {sw, rst, val, stp, rep};
   endfunction

   task automatic drive(input logic [14:0] r);
      i_Switches = r[14:11];
      i_Reset    = r[10];
      exp_q.push_back(r[9:0]);
      @(posedge i_Clk);
      #1;
   endtask

   task automatic test_reset();
      logic [14:0] rows[$];
      logic [9:0]  e;
      logic [9:0]  got;
      rows.push_back(row(4'b0000, 1'b1, 8'h00, 1'b0, 1'b0));
      rows.push_back(row(4'b0000, 1'b1, 8'h00, 1'b0, 1'b0));
      rows.push_back(row(4'b0000, 1'b0, 8'h00, 1'b0, 1'b0));
      foreach (rows[i]) begin
         drive(rows[i]);
         e   = exp_q.pop_front();
         got = {o_Tens, o_Ones, o_Step, o_Repeating};
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL reset[%0d]: got val=%h step=%b rep=%b, expected val=%h step=%b rep=%b",
                     i, got[9:2], got[1], got[0], e[9:2], e[1], e[0]);
         end
      end
   endtask

   task automatic test_single_press();
      logic [14:0] rows[$];
      logic [9:0]  e;
      logic [9:0]  got;
      rows.push_back(row(4'b0001, 1'b0, 8'h01, 1'b1, 1'b0));
      rows.push_back(row(4'b0001, 1'b0, 8'h01, 1'b0, 1'b0));
      rows.push_back(row(4'b0001, 1'b0, 8'h01, 1'b0, 1'b0));
      rows.push_back(row(4'b0000, 1'b0, 8'h01, 1'b0, 1'b0));
      rows.push_back(row(4'b0000, 1'b0, 8'h01, 1'b0, 1'b0));
      foreach (rows[i]) begin
         drive(rows[i]);
         e   = exp_q.pop_front();
         got = {o_Tens, o_Ones, o_Step, o_Repeating};
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL single_press[%0d]: got val=%h step=%b rep=%b, expected val=%h step=%b rep=%b",
                     i, got[9:2], got[1], got[0], e[9:2], e[1], e[0]);
         end
      end
   endtask

   task automatic test_wrap();
      logic [14:0] rows[$];
      logic [9:0]  e;
      logic [9:0]  got;
      rows.push_back(row(4'b0010, 1'b0, 8'h00, 1'b1, 1'b0));
      rows.push_back(row(4'b0000, 1'b0, 8'h00, 1'b0, 1'b0));
      rows.push_back(row(4'b0010, 1'b0, 8'h99, 1'b1, 1'b0));
      rows.push_back(row(4'b0000, 1'b0, 8'h99, 1'b0, 1'b0));
      rows.push_back(row(4'b0001, 1'b0, 8'h00, 1'b1, 1'b0));
      rows.push_back(row(4'b0000, 1'b0, 8'h00, 1'b0, 1'b0));
      foreach (rows[i]) begin
         drive(rows[i]);
         e   = exp_q.pop_front();
         got = {o_Tens, o_Ones, o_Step, o_Repeating};
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL wrap[%0d]: got val=%h step=%b rep=%b, expected val=%h step=%b rep=%b",
                     i, got[9:2], got[1], got[0], e[9:2], e[1], e[0]);
         end
      end
   endtask

   task automatic test_hold_repeat();
      logic [14:0] rows[$];
      logic [9:0]  e;
      logic [9:0]  got;
      logic [7:0]  v;
      for (int c = 0; c < 20; c++) begin
         v = (c < 8) ? 8'h01 : (c < 12) ? 8'h02 : (c < 16) ? 8'h03 : 8'h04;
         rows.push_back(row(4'b0001, 1'b0, v, (c == 0 || c == 8 || c == 12 || c == 16),
                            (c >= 8)));
      end
      rows.push_back(row(4'b0000, 1'b0, 8'h04, 1'b0, 1'b0));
      rows.push_back(row(4'b0000, 1'b0, 8'h04, 1'b0, 1'b0));
      foreach (rows[i]) begin
         drive(rows[i]);
         e   = exp_q.pop_front();
         got = {o_Tens, o_Ones, o_Step, o_Repeating};
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL hold_repeat[%0d]: got val=%h step=%b rep=%b, expected val=%h step=%b rep=%b",
                     i, got[9:2], got[1], got[0], e[9:2], e[1], e[0]);
         end
      end
   endtask

   task automatic test_clear_in_repeat();
      logic [14:0] rows[$];
      logic [9:0]  e;
      logic [9:0]  got;
      for (int c = 0; c < 9; c++)
         rows.push_back(row(4'b0001, 1'b0, (c < 8) ? 8'h05 : 8'h06, (c == 0 || c == 8),
                            (c == 8)));
      rows.push_back(row(4'b0101, 1'b0, 8'h00, 1'b1, 1'b0));
      for (int c = 0; c < 12; c++)
         rows.push_back(row(4'b0001, 1'b0, 8'h00, 1'b0, 1'b0));
      rows.push_back(row(4'b0000, 1'b0, 8'h00, 1'b0, 1'b0));
      foreach (rows[i]) begin
         drive(rows[i]);
         e   = exp_q.pop_front();
         got = {o_Tens, o_Ones, o_Step, o_Repeating};
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL clear_in_repeat[%0d]: got val=%h step=%b rep=%b, expected val=%h step=%b rep=%b",
                     i, got[9:2], got[1], got[0], e[9:2], e[1], e[0]);
         end
      end
   endtask

   task automatic test_priority();
      logic [14:0] rows[$];
      logic [9:0]  e;
      logic [9:0]  got;
      rows.push_back(row(4'b1100, 1'b0, 8'h00, 1'b1, 1'b0));
      rows.push_back(row(4'b0000, 1'b0, 8'h00, 1'b0, 1'b0));
      rows.push_back(row(4'b1000, 1'b0, 8'h50, 1'b1, 1'b0));
      rows.push_back(row(4'b0000, 1'b0, 8'h50, 1'b0, 1'b0));
      rows.push_back(row(4'b0010, 1'b0, 8'h49, 1'b1, 1'b0));
      rows.push_back(row(4'b0000, 1'b0, 8'h49, 1'b0, 1'b0));
      rows.push_back(row(4'b0001, 1'b0, 8'h50, 1'b1, 1'b0));
      rows.push_back(row(4'b0000, 1'b0, 8'h50, 1'b0, 1'b0));
      rows.push_back(row(4'b0011, 1'b0, 8'h50, 1'b0, 1'b0));
      rows.push_back(row(4'b0000, 1'b0, 8'h50, 1'b0, 1'b0));
      foreach (rows[i]) begin
         drive(rows[i]);
         e   = exp_q.pop_front();
         got = {o_Tens, o_Ones, o_Step, o_Repeating};
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL priority[%0d]: got val=%h step=%b rep=%b, expected val=%h step=%b rep=%b",
                     i, got[9:2], got[1], got[0], e[9:2], e[1], e[0]);
         end
      end
   endtask

   task automatic test_reset_hold();
      logic [14:0] rows[$];
      logic [9:0]  e;
      logic [9:0]  got;
      rows.push_back(row(4'b0001, 1'b1, 8'h00, 1'b0, 1'b0));
      rows.push_back(row(4'b0001, 1'b1, 8'h00, 1'b0, 1'b0));
      for (int c = 0; c < 10; c++)
         rows.push_back(row(4'b0001, 1'b0, 8'h00, 1'b0, 1'b0));
      rows.push_back(row(4'b0000, 1'b0, 8'h00, 1'b0, 1'b0));
      rows.push_back(row(4'b0001, 1'b0, 8'h01, 1'b1, 1'b0));
      rows.push_back(row(4'b0000, 1'b0, 8'h01, 1'b0, 1'b0));
      foreach (rows[i]) begin
         drive(rows[i]);
         e   = exp_q.pop_front();
         got = {o_Tens, o_Ones, o_Step, o_Repeating};
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL reset_hold[%0d]: got val=%h step=%b rep=%b, expected val=%h step=%b rep=%b",
                     i, got[9:2], got[1], got[0], e[9:2], e[1], e[0]);
         end
      end
   endtask

   initial begin
      i_Reset    = 1'b1;
      i_Switches = 4'b0000;
      test_reset();
      test_single_press();
      test_wrap();
      test_hold_repeat();
      test_clear_in_repeat();
      test_priority();
      test_reset_hold();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/switch_event_counter.md
# switch_event_counter

Consumes the four debounced switch levels from the debounce stage and turns them into a two-digit BCD value (00–99) for the 7-segment display path. Press edges increment, decrement, clear or preset the value. Holding increment or decrement auto-repeats after a delay. Sits between the debounce stage and the binary/BCD-to-7-segment decoders.

## Interface
- REPEAT_DELAY, 12_500_000: cycles from the initial step to the first auto-repeat step (0.5 s at 25 MHz); legal range ≥ 2.
- REPEAT_PERIOD, 2_500_000: cycles between auto-repeat steps (0.1 s at 25 MHz); legal range ≥ 2.
- PRESET, 50: decimal value loaded by switch 4; legal range 0–99.
- i_Clk  in  1  system clock; the only clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Switches  in  4  debounced levels, 1 = pressed. Bit mapping:
  - bit0: increment.
  - bit1: decrement.
  - bit2: clear.
  - bit3: preset.
- o_Tens  out  4  BCD tens digit, 0–9.
- o_Ones  out  4  BCD ones digit, 0–9.
- o_Step  out  1  one-cycle pulse, high in the first cycle a newly applied action is visible on the digits.
- o_Repeating  out  1  high while the FSM is in REPEAT.

## Operation
- Edge detection: r_Switches holds the previous i_Switches. press[n] = i_Switches[n] & ~r_Switches[n]. Release edges are ignored.
- Actions per clock, highest priority first:
  - press[2]: value := 00.
  - press[3]: value := PRESET.
  - Increment/decrement step: the press edge or repeat timer of the active direction.
- Any action pulses o_Step, including a clear when the value is already 00.
- Increment and decrement held together (i_Switches[1:0] = 11) produce no step and force IDLE.
- BCD arithmetic:
  - ones 9 + 1 → 0, with a carry into tens.
  - ones 0 − 1 → 9, with a borrow from tens.
  - 99 + 1 → 00 and 00 − 1 → 99 (wrap).
- FSM states: IDLE, DELAY, REPEAT. The held direction is latched in r_Dir.
  - IDLE: on press[0] xor press[1], apply one step, latch r_Dir, timer := REPEAT_DELAY−1, go to DELAY.
  - DELAY: if the held switch is released, the other direction switch goes high, or press[2] or press[3] occurs, go to IDLE. Otherwise, when the timer reaches 0, apply a step, timer := REPEAT_PERIOD−1, go to REPEAT. Otherwise decrement the timer.
  - REPEAT: same exit conditions as DELAY. When the timer reaches 0, apply a step and reload REPEAT_PERIOD−1.
- Exit conditions take priority over a coincident timer expiry; no step is applied on that cycle.
- Timer width is $clog2 of max(REPEAT_DELAY, REPEAT_PERIOD).

## Timing
- Reset values:
  - o_Tens = 0, o_Ones = 0, o_Step = 0, o_Repeating = 0.
  - FSM = IDLE, timer = 0.
  - r_Switches := i_Switches, so a switch held through reset produces no edge.
- Reset mid-repeat: return to IDLE. A held switch does not step again until it is released and re-pressed.
- Latency: a press sampled at clock edge k updates the digits and o_Step at edge k. The new value is visible one clock after the first sampling edge.
- Repeat steps occur at edge k+REPEAT_DELAY, then every REPEAT_PERIOD edges.
- o_Repeating rises together with the first repeat step's o_Step.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package switch_counter_pkg:
  - state enum (IDLE, DELAY, REPEAT).
  - bcd_digit_t (4-bit) typedef.
  - direction constants DIR_UP / DIR_DOWN.
- Sub-module bcd_updown_counter: two-digit BCD register with clear, load, up and down controls and a priority mux. Instantiated once.
- The FSM, timer and edge detect live in switch_event_counter.

## Test plan
All tests use REPEAT_DELAY=8, REPEAT_PERIOD=4, PRESET=50.
- Reset, then pulse bit0 high for 3 cycles → 01, one o_Step, o_Repeating never high.
- Start at 99, press bit0 → 00. Start at 00, press bit1 → 99.
- Hold bit0 for 20 cycles from 00:
  - steps at cycles 0, 8, 12, 16 → 04.
  - o_Repeating high from cycle 8.
  - goes low the cycle after release.
- While holding bit0 in REPEAT, press bit2 → 00, o_Step pulse, FSM IDLE, no further steps while bit0 stays high.
- Same-cycle press of bit2 and bit3 → 00 (clear wins). Press bit3 alone → 50. Bits 0 and 1 pressed together → no change.
- Hold bit0 across a 2-cycle i_Reset → 00 after reset, no step until bit0 is released and re-pressed.
